// File: rtl/skew_pkg.sv
// Shared types and helpers for the systolic skew buffer.
package skew_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } skew_state_t;

  // DESKEW=0 staircases lane i by i cycles, DESKEW=1 reverses the staircase.
  function automatic int lane_delay(input int i, input int matrix_size, input int deskew);
    return (deskew == 0) ? i : (matrix_size - 1 - i);
  endfunction

  function automatic int max_delay_lane(input int matrix_size, input int deskew);
    return (deskew == 0) ? (matrix_size - 1) : 0;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane of the skew buffer: a DEPTH-stage delay line carrying data, a
// valid bit and an optional tag bit. DEPTH=0 is a gated pass-through.
module skew_lane #(
  parameter int DEPTH     = 1,
  parameter int DATA_SIZE = 32,
  parameter bit HAS_TAG   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_tag,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_tag
);

  localparam int REGS = (DEPTH > 0) ? DEPTH : 1;

  logic                 insValid;
  logic                 insTag;
  logic [DATA_SIZE-1:0] insData;

  logic [REGS-1:0]      valid_q;
  logic [REGS-1:0]      tag_q;
  logic [DATA_SIZE-1:0] data_q [REGS];

  // Bubbles are inserted as zero so data never needs masking at the output.
  assign insValid = in_valid & enable;
  assign insData  = insValid ? in_data : '0;
  assign insTag   = HAS_TAG & insValid & in_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      tag_q   <= '0;
      for (int k = 0; k < REGS; k++) data_q[k] <= '0;
    end else if (enable) begin
      valid_q[0] <= insValid;
      tag_q[0]   <= insTag;
      data_q[0]  <= insData;
      for (int k = 1; k < REGS; k++) begin
        valid_q[k] <= valid_q[k-1];
        tag_q[k]   <= tag_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  assign out_valid = (DEPTH == 0) ? insValid : valid_q[REGS-1];
  assign out_tag   = (DEPTH == 0) ? insTag   : tag_q[REGS-1];
  assign out_data  = (DEPTH == 0) ? insData  : data_q[REGS-1];

endmodule

// File: rtl/systolic_skew_buffer.sv
// Skews (or deskews) a vector of lane elements into a diagonal wavefront and
// tracks stream completion through a last tag on the longest lane.
module systolic_skew_buffer
  import skew_pkg::*;
#(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_SIZE   = 32,
  parameter int DESKEW      = 0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 enable,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_in,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_out,
  output logic [MATRIX_SIZE-1:0]               lane_valid,
  output logic                                 busy,
  output logic                                 done
);

  localparam int MAXD     = MATRIX_SIZE - 1;
  localparam int MAX_LANE = max_delay_lane(MATRIX_SIZE, DESKEW);

  skew_state_t           state_q;
  logic                  accept;
  logic [MATRIX_SIZE-1:0] laneTag;

  // Reset also gates the zero-delay lane so outputs clear immediately.
  assign in_ready = (state_q != DRAIN);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid & in_ready & enable & reset_n;

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    skew_lane #(
      .DEPTH     (lane_delay(i, MATRIX_SIZE, DESKEW)),
      .DATA_SIZE (DATA_SIZE),
      .HAS_TAG   (i == MAX_LANE)
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .in_valid  (accept),
      .in_data   (data_in[i]),
      .in_tag    (in_last),
      .out_valid (lane_valid[i]),
      .out_data  (data_out[i]),
      .out_tag   (laneTag[i])
    );
  end

  // Only the max-delay lane can carry a tag, so the reduction picks out that lane.
  assign done = enable & (|(lane_valid & laneTag));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            if (!in_last)      state_q <= STREAM;
            else if (MAXD > 0) state_q <= DRAIN;
            else               state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Randomized self-checking bench: two 4-lane instances (skew and deskew)
// share stimulus, a 1-lane instance runs separately; all compared to a history model.
module tb_systolic_skew_buffer;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic enable;
  logic validA, lastA, validB, lastB;
  logic [3:0][DW-1:0] dataA;
  logic [0:0][DW-1:0] dataB;

  logic [3:0][DW-1:0] dout0, dout1;
  logic [0:0][DW-1:0] dout2;
  logic [3:0] lv0, lv1;
  logic [0:0] lv2;
  logic ready0, ready1, ready2, busy0, busy1, busy2, done0, done1, done2;

  systolic_skew_buffer #(.MATRIX_SIZE(4), .DATA_SIZE(DW), .DESKEW(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(validA), .in_last(lastA),
    .in_ready(ready0), .data_in(dataA), .data_out(dout0), .lane_valid(lv0),
    .busy(busy0), .done(done0));

  systolic_skew_buffer #(.MATRIX_SIZE(4), .DATA_SIZE(DW), .DESKEW(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(validA), .in_last(lastA),
    .in_ready(ready1), .data_in(dataA), .data_out(dout1), .lane_valid(lv1),
    .busy(busy1), .done(done1));

  systolic_skew_buffer #(.MATRIX_SIZE(1), .DATA_SIZE(DW), .DESKEW(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(validB), .in_last(lastB),
    .in_ready(ready2), .data_in(dataB), .data_out(dout2), .lane_valid(lv2),
    .busy(busy2), .done(done2));

  // Reference model: for each instance, the last four inserted beats by age
  // (age 0 = inserted one enabled cycle ago), plus stream/drain bookkeeping.
  int nLanes [3] = '{4, 4, 1};
  int desk   [3] = '{0, 1, 0};
  logic [3:0][DW-1:0] hData [3][4];
  bit hValid [3][4];
  bit hLast  [3][4];
  bit draining [3];
  bit streaming [3];

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int laneDelay(input int k, input int i);
    return (desk[k] != 0) ? (nLanes[k] - 1 - i) : i;
  endfunction

  task automatic clearModel();
    for (int k = 0; k < 3; k++) begin
      draining[k]  = 1'b0;
      streaming[k] = 1'b0;
      for (int a = 0; a < 4; a++) begin
        hData[k][a]  = '0;
        hValid[k][a] = 1'b0;
        hLast[k][a]  = 1'b0;
      end
    end
  endtask

  task automatic evalDut(input int k, input bit v, input bit l, input logic [3:0][DW-1:0] din,
                         input logic [3:0][DW-1:0] obsData, input logic [3:0] obsLv,
                         input bit obsReady, input bit obsBusy, input bit obsDone);
    bit ready, acc, eDone;
    logic [3:0][DW-1:0] eD;
    logic [3:0] eLv;
    int d;
    ready = !draining[k];
    acc   = v & ready & enable & reset_n;
    eD    = '0;
    eLv   = '0;
    eDone = 1'b0;
    for (int i = 0; i < nLanes[k]; i++) begin
      d = laneDelay(k, i);
      if (d == 0) begin
        if (acc) begin
          eLv[i] = 1'b1;
          eD[i]  = din[i];
        end
        if (d == nLanes[k] - 1) eDone = enable & acc & l;
      end else begin
        if (hValid[k][d-1]) begin
          eLv[i] = 1'b1;
          eD[i]  = hData[k][d-1][i];
        end
        if (d == nLanes[k] - 1) eDone = enable & hValid[k][d-1] & hLast[k][d-1];
      end
    end
    checkOutput($sformatf("d%0d_data", k), obsData, eD);
    checkOutput($sformatf("d%0d_lane_valid", k), obsLv, eLv);
    checkOutput($sformatf("d%0d_in_ready", k), obsReady, ready);
    checkOutput($sformatf("d%0d_busy", k), obsBusy, streaming[k] | draining[k]);
    checkOutput($sformatf("d%0d_done", k), obsDone, eDone);
    if (enable && reset_n) begin
      if (eDone) draining[k] = 1'b0;
      if (acc) begin
        if (l) begin
          streaming[k] = 1'b0;
          if (nLanes[k] > 1) draining[k] = 1'b1;
        end else begin
          streaming[k] = 1'b1;
        end
      end
      for (int a = 3; a > 0; a--) begin
        hData[k][a]  = hData[k][a-1];
        hValid[k][a] = hValid[k][a-1];
        hLast[k][a]  = hLast[k][a-1];
      end
      hData[k][0]  = acc ? din : '0;
      hValid[k][0] = acc;
      hLast[k][0]  = acc & l;
    end
  endtask

  task automatic applyStimulus(input bit en, input bit vA, input bit lA, input logic [3:0][DW-1:0] dA,
                               input bit vB, input bit lB, input logic [DW-1:0] dB);
    @(negedge clk);
    enable   = en;
    validA   = vA;
    lastA    = lA;
    dataA    = dA;
    validB   = vB;
    lastB    = lB;
    dataB[0] = dB;
    #1;
    evalDut(0, vA, lA, dA, dout0, lv0, ready0, busy0, done0);
    evalDut(1, vA, lA, dA, dout1, lv1, ready1, busy1, done1);
    evalDut(2, vB, lB, {96'b0, dB}, {96'b0, dout2}, {3'b0, lv2}, ready2, busy2, done2);
  endtask

  // Asserts reset mid-cycle with a beat still offered, checks outputs clear at once.
  task automatic doReset();
    @(negedge clk);
    #2;
    enable  = 1'b1;
    validA  = 1'b1;
    validB  = 1'b1;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_data0", dout0, '0);
    checkOutput("rst_lv0", lv0, '0);
    checkOutput("rst_done0", done0, 1'b0);
    checkOutput("rst_data1", dout1, '0);
    checkOutput("rst_lv1", lv1, '0);
    checkOutput("rst_done1", done1, 1'b0);
    checkOutput("rst_data2", dout2, '0);
    checkOutput("rst_lv2", lv2, '0);
    checkOutput("rst_done2", done2, 1'b0);
    clearModel();
    repeat (2) @(negedge clk);
    validA  = 1'b0;
    validB  = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_ready0", ready0, 1'b1);
    checkOutput("post_rst_busy0", busy0, 1'b0);
    checkOutput("post_rst_ready2", ready2, 1'b1);
    checkOutput("post_rst_busy2", busy2, 1'b0);
  endtask

  initial begin
    logic [3:0][DW-1:0] rd;
    logic [3:0][DW-1:0] seq;
    bit en, vA, lA, vB, lB;
    reset_n = 1'b1;
    enable  = 1'b0;
    validA  = 1'b0;
    lastA   = 1'b0;
    validB  = 1'b0;
    lastB   = 1'b0;
    dataA   = '0;
    dataB   = '0;
    clearModel();
    doReset();

    // Single last beat (1,2,3,4) on the 4-lane pair and beat 7 on the 1-lane instance.
    seq = {32'd4, 32'd3, 32'd2, 32'd1};
    applyStimulus(1'b1, 1'b1, 1'b1, seq, 1'b1, 1'b1, 32'd7);
    checkOutput("skew_lane0_c0", dout0[0], 32'd1);
    checkOutput("deskew_lane3_c0", dout1[3], 32'd4);
    checkOutput("n1_data", dout2[0], 32'd7);
    checkOutput("n1_done", done2, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      if (c == 1) checkOutput("skew_lane1_c1", dout0[1], 32'd2);
      if (c == 2) checkOutput("deskew_lane1_c2", dout1[1], 32'd2);
      if (c == 3) begin
        checkOutput("skew_lane3_c3", dout0[3], 32'd4);
        checkOutput("skew_done_c3", done0, 1'b1);
        checkOutput("deskew_lane0_c3", dout1[0], 32'd1);
        checkOutput("ready_c3", ready0, 1'b0);
      end
      if (c == 4) begin
        checkOutput("ready_c4", ready0, 1'b1);
        checkOutput("n1_busy_c4", busy2, 1'b0);
      end
    end

    for (int n = 0; n < 900; n++) begin
      if (n == 300 || n == 600) doReset();
      en = ($urandom_range(0, 99) < 85);
      vA = ($urandom_range(0, 99) < 70);
      lA = ($urandom_range(0, 99) < 20);
      vB = ($urandom_range(0, 99) < 70);
      lB = ($urandom_range(0, 99) < 30);
      for (int i = 0; i < 4; i++) rd[i] = $urandom;
      applyStimulus(en, vA, lA, rd, vB, lB, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
